axis_packet_fifo: RTL and testbench

AXIS_PACKET_FIFO -- requirements
Module: axis_packet_fifo

---
 rtl/axis_packet_fifo.sv | 107 ++++++++++
 tb/tb_axis_packet_fifo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_fifo.sv
// AXI-Stream FIFO with a registered output stage and optional store-and-forward
// (packet) mode that holds data back until a complete tlast-terminated packet is stored.
module axis_packet_fifo #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int ADDR_WIDTH       = 9,
  parameter int PACKET_MODE      = 0
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        flush,
  input  logic [ADDR_WIDTH:0]         cfg_almost_full,
  input  logic [ADDR_WIDTH:0]         cfg_almost_empty,
  output logic [ADDR_WIDTH:0]         count,
  output logic [ADDR_WIDTH:0]         packets,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic                        oversize,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tlast,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [AXIS_TDATA_WIDTH:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]       wr_ptr;
  logic [ADDR_WIDTH:0]       rd_ptr;
  logic [AXIS_TDATA_WIDTH:0] rd_word;
  logic                      mem_full;
  logic                      mem_empty;
  logic                      read_ok;
  logic                      wr_en;
  logic                      load;
  logic                      over_cond;
  logic                      over_prev;

  assign mem_full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                     (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign mem_empty = (wr_ptr == rd_ptr);
  assign rd_word   = mem[rd_ptr[ADDR_WIDTH-1:0]];

  assign s_axis_tready = ~mem_full & ~flush;
  assign wr_en         = s_axis_tvalid & s_axis_tready;

  // A full memory with no complete packet falls back to cut-through so the FIFO cannot deadlock.
  assign read_ok   = (PACKET_MODE == 0) ? 1'b1 : ((packets != '0) || mem_full);
  assign over_cond = (PACKET_MODE != 0) && mem_full && (packets == '0);
  assign load      = read_ok & ~mem_empty & (~m_axis_tvalid | m_axis_tready) & ~flush;

  assign count        = (wr_ptr - rd_ptr) + {{ADDR_WIDTH{1'b0}}, m_axis_tvalid};
  assign almost_full  = (count >= cfg_almost_full);
  assign almost_empty = (count <= cfg_almost_empty);

  always_ff @(posedge aclk) begin
    if (wr_en) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  always_ff @(posedge aclk) begin
    if (load) begin
      {m_axis_tlast, m_axis_tdata} <= rd_word;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      packets       <= '0;
      m_axis_tvalid <= 1'b0;
      oversize      <= 1'b0;
      over_prev     <= 1'b0;
    end else if (flush) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      packets       <= '0;
      m_axis_tvalid <= 1'b0;
      oversize      <= 1'b0;
      over_prev     <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (load) begin
        rd_ptr        <= rd_ptr + 1'b1;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      case ({wr_en & s_axis_tlast, load & rd_word[AXIS_TDATA_WIDTH]})
        2'b10:   packets <= packets + 1'b1;
        2'b01:   packets <= packets - 1'b1;
        default: packets <= packets;
      endcase
      // Rising-edge detect keeps oversize a single-cycle pulse even if the memory stays full.
      over_prev <= over_cond;
      oversize  <= over_cond & ~over_prev;
    end
  end

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Directed self-checking bench: one word-mode and one packet-mode instance of
// axis_packet_fifo (ADDR_WIDTH=4, 32-bit data) sharing clock, reset, flush and thresholds.
module tb_axis_packet_fifo;

  logic        aclk = 1'b0;
  logic        areset;
  logic        flush;
  logic [4:0]  cfg_af;
  logic [4:0]  cfg_ae;

  logic [31:0] w_s_tdata, w_m_tdata;
  logic        w_s_tlast, w_s_tvalid, w_s_tready;
  logic        w_m_tlast, w_m_tvalid, w_m_tready;
  logic [4:0]  w_count, w_packets;
  logic        w_af, w_ae, w_over;

  logic [31:0] p_s_tdata, p_m_tdata;
  logic        p_s_tlast, p_s_tvalid, p_s_tready;
  logic        p_m_tlast, p_m_tvalid, p_m_tready;
  logic [4:0]  p_count, p_packets;
  logic        p_af, p_ae, p_over;

  int errors = 0;
  int checks = 0;

  always #5 aclk = ~aclk;

  axis_packet_fifo #(.AXIS_TDATA_WIDTH(32), .ADDR_WIDTH(4), .PACKET_MODE(0)) dut_word (
    .aclk(aclk), .areset(areset), .flush(flush),
    .cfg_almost_full(cfg_af), .cfg_almost_empty(cfg_ae),
    .count(w_count), .packets(w_packets),
    .almost_full(w_af), .almost_empty(w_ae), .oversize(w_over),
    .s_axis_tdata(w_s_tdata), .s_axis_tlast(w_s_tlast),
    .s_axis_tvalid(w_s_tvalid), .s_axis_tready(w_s_tready),
    .m_axis_tdata(w_m_tdata), .m_axis_tlast(w_m_tlast),
    .m_axis_tvalid(w_m_tvalid), .m_axis_tready(w_m_tready)
  );

  axis_packet_fifo #(.AXIS_TDATA_WIDTH(32), .ADDR_WIDTH(4), .PACKET_MODE(1)) dut_pkt (
    .aclk(aclk), .areset(areset), .flush(flush),
    .cfg_almost_full(cfg_af), .cfg_almost_empty(cfg_ae),
    .count(p_count), .packets(p_packets),
    .almost_full(p_af), .almost_empty(p_ae), .oversize(p_over),
    .s_axis_tdata(p_s_tdata), .s_axis_tlast(p_s_tlast),
    .s_axis_tvalid(p_s_tvalid), .s_axis_tready(p_s_tready),
    .m_axis_tdata(p_m_tdata), .m_axis_tlast(p_m_tlast),
    .m_axis_tvalid(p_m_tvalid), .m_axis_tready(p_m_tready)
  );

  task automatic test_reset();
    areset = 1'b1; flush = 1'b0; cfg_af = 5'd17; cfg_ae = 5'd2;
    w_s_tdata = '0; w_s_tlast = 1'b0; w_s_tvalid = 1'b0; w_m_tready = 1'b0;
    p_s_tdata = '0; p_s_tlast = 1'b0; p_s_tvalid = 1'b0; p_m_tready = 1'b0;
    #12;
    checks++; if (w_count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", w_count); end
    checks++; if (w_m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid: got %b expected 0", w_m_tvalid); end
    checks++; if (p_packets !== 5'd0) begin errors++; $display("[TB] FAIL reset_packets: got %0d expected 0", p_packets); end
    checks++; if (p_over !== 1'b0) begin errors++; $display("[TB] FAIL reset_oversize: got %b expected 0", p_over); end
    checks++; if (w_ae !== 1'b1 || w_af !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got ae=%b af=%b expected ae=1 af=0", w_ae, w_af); end
    @(negedge aclk); areset = 1'b0;
    @(negedge aclk);
    checks++; if (w_s_tready !== 1'b1 || p_s_tready !== 1'b1) begin errors++; $display("[TB] FAIL reset_tready: got w=%b p=%b expected 1", w_s_tready, p_s_tready); end
  endtask

  task automatic test_word_fill();
    bit exp_b;
    w_m_tready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      w_s_tvalid = 1'b1; w_s_tdata = 32'(i); w_s_tlast = 1'b0;
      @(negedge aclk);
      checks++; if (w_count !== 5'(i)) begin errors++; $display("[TB] FAIL fill_count[%0d]: got %0d expected %0d", i, w_count, i); end
      exp_b = (i < 17);
      checks++; if (w_s_tready !== exp_b) begin errors++; $display("[TB] FAIL fill_tready[%0d]: got %b expected %b", i, w_s_tready, exp_b); end
      exp_b = (i >= 2);
      checks++; if (w_m_tvalid !== exp_b) begin errors++; $display("[TB] FAIL fill_tvalid[%0d]: got %b expected %b", i, w_m_tvalid, exp_b); end
      if (i >= 2) begin
        checks++; if (w_m_tdata !== 32'h1) begin errors++; $display("[TB] FAIL fill_hold_data[%0d]: got %0h expected 1", i, w_m_tdata); end
      end
      exp_b = (i >= 17);
      checks++; if (w_af !== exp_b) begin errors++; $display("[TB] FAIL fill_almost_full[%0d]: got %b expected %b", i, w_af, exp_b); end
    end
    w_s_tdata = 32'h12;
    @(negedge aclk);
    checks++; if (w_count !== 5'd17) begin errors++; $display("[TB] FAIL fill_overflow_count: got %0d expected 17", w_count); end
    w_s_tvalid = 1'b0; w_m_tready = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      checks++; if (w_m_tvalid !== 1'b1 || w_m_tdata !== 32'(k)) begin errors++; $display("[TB] FAIL drain_word[%0d]: got v=%b d=%0h expected v=1 d=%0h", k, w_m_tvalid, w_m_tdata, k); end
      @(negedge aclk);
    end
    checks++; if (w_m_tvalid !== 1'b0 || w_count !== 5'd0) begin errors++; $display("[TB] FAIL drain_empty: got v=%b count=%0d expected v=0 count=0", w_m_tvalid, w_count); end
    w_m_tready = 1'b0;
  endtask

  task automatic test_stream();
    localparam int N = 8;
    w_m_tready = 1'b1;
    for (int k = 1; k <= N + 1; k++) begin
      if (k <= N) begin w_s_tvalid = 1'b1; w_s_tdata = 32'h100 + 32'(k); end
      else w_s_tvalid = 1'b0;
      @(negedge aclk);
      if (k == 1) begin
        checks++; if (w_m_tvalid !== 1'b0 || w_count !== 5'd1) begin errors++; $display("[TB] FAIL stream_first: got v=%b count=%0d expected v=0 count=1", w_m_tvalid, w_count); end
      end else begin
        checks++; if (w_m_tvalid !== 1'b1 || w_m_tdata !== 32'h100 + 32'(k - 1)) begin errors++; $display("[TB] FAIL stream_word[%0d]: got v=%b d=%0h expected v=1 d=%0h", k, w_m_tvalid, w_m_tdata, 32'h100 + 32'(k - 1)); end
        checks++; if (w_count !== ((k <= N) ? 5'd2 : 5'd1)) begin errors++; $display("[TB] FAIL stream_count[%0d]: got %0d expected %0d", k, w_count, (k <= N) ? 2 : 1); end
      end
    end
    @(negedge aclk);
    checks++; if (w_m_tvalid !== 1'b0 || w_count !== 5'd0) begin errors++; $display("[TB] FAIL stream_end: got v=%b count=%0d expected v=0 count=0", w_m_tvalid, w_count); end
    w_m_tready = 1'b0;
  endtask

  task automatic test_packet();
    bit exp_b;
    p_m_tready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      p_s_tvalid = 1'b1; p_s_tdata = 32'hA0 + 32'(k); p_s_tlast = (k == 3);
      @(negedge aclk);
      checks++; if (p_m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL pkt_hold[%0d]: got %b expected 0", k, p_m_tvalid); end
    end
    checks++; if (p_packets !== 5'd1) begin errors++; $display("[TB] FAIL pkt_count_up: got %0d expected 1", p_packets); end
    p_s_tvalid = 1'b0; p_s_tlast = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge aclk);
      exp_b = (k == 3);
      checks++; if (p_m_tvalid !== 1'b1 || p_m_tdata !== 32'hA0 + 32'(k) || p_m_tlast !== exp_b) begin errors++; $display("[TB] FAIL pkt_word[%0d]: got v=%b d=%0h l=%b expected v=1 d=%0h l=%b", k, p_m_tvalid, p_m_tdata, p_m_tlast, 32'hA0 + 32'(k), exp_b); end
      checks++; if (p_packets !== ((k == 3) ? 5'd0 : 5'd1)) begin errors++; $display("[TB] FAIL pkt_packets[%0d]: got %0d expected %0d", k, p_packets, (k == 3) ? 0 : 1); end
    end
    @(negedge aclk);
    checks++; if (p_m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL pkt_done: got %b expected 0", p_m_tvalid); end
  endtask

  task automatic test_oversize();
    int sent = 0, got = 0, pulses = 0, cyc = 0;
    bit prev_over = 1'b0, first_seen = 1'b0;
    p_m_tready = 1'b1;
    while (got < 21 && cyc < 300) begin
      if (sent < 21) begin
        p_s_tvalid = 1'b1; p_s_tdata = 32'h200 + 32'(sent); p_s_tlast = (sent == 20);
      end else begin
        p_s_tvalid = 1'b0; p_s_tlast = 1'b0;
      end
      #1;
      if (p_over === 1'b1) begin
        pulses++;
        checks++; if (prev_over) begin errors++; $display("[TB] FAIL oversize_width: got 2-cycle pulse expected 1-cycle"); end
      end
      prev_over = (p_over === 1'b1);
      if (p_m_tvalid === 1'b1) begin
        if (!first_seen) begin
          checks++; if (sent != 16) begin errors++; $display("[TB] FAIL oversize_first_out: got sent=%0d expected 16", sent); end
          first_seen = 1'b1;
        end
        checks++; if (p_m_tdata !== 32'h200 + 32'(got)) begin errors++; $display("[TB] FAIL oversize_order[%0d]: got %0h expected %0h", got, p_m_tdata, 32'h200 + 32'(got)); end
        if (got == 20) begin
          checks++; if (p_m_tlast !== 1'b1) begin errors++; $display("[TB] FAIL oversize_tlast: got %b expected 1", p_m_tlast); end
        end
        got++;
      end
      if (p_s_tvalid && p_s_tready) sent++;
      @(negedge aclk);
      cyc++;
    end
    p_s_tvalid = 1'b0; p_s_tlast = 1'b0;
    checks++; if (got != 21) begin errors++; $display("[TB] FAIL oversize_timeout: got %0d words expected 21", got); end
    checks++; if (pulses < 1) begin errors++; $display("[TB] FAIL oversize_pulse: got %0d pulses expected at least 1", pulses); end
    checks++; if (p_count !== 5'd0 || p_packets !== 5'd0) begin errors++; $display("[TB] FAIL oversize_end: got count=%0d packets=%0d expected 0 0", p_count, p_packets); end
    p_m_tready = 1'b0;
  endtask

  task automatic test_flush();
    bit exp_b;
    w_m_tready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      w_s_tvalid = 1'b1; w_s_tdata = 32'h300 + 32'(k); w_s_tlast = (k == 3 || k == 5);
      @(negedge aclk);
      checks++; if (w_count !== 5'(k)) begin errors++; $display("[TB] FAIL flush_fill_count[%0d]: got %0d expected %0d", k, w_count, k); end
      exp_b = (k <= 2);
      checks++; if (w_ae !== exp_b) begin errors++; $display("[TB] FAIL almost_empty[%0d]: got %b expected %b", k, w_ae, exp_b); end
    end
    checks++; if (w_packets !== 5'd2) begin errors++; $display("[TB] FAIL flush_pre_packets: got %0d expected 2", w_packets); end
    checks++; if (w_m_tvalid !== 1'b1 || w_m_tdata !== 32'h301 || w_m_tlast !== 1'b0) begin errors++; $display("[TB] FAIL flush_pre_out: got v=%b d=%0h l=%b expected v=1 d=301 l=0", w_m_tvalid, w_m_tdata, w_m_tlast); end
    flush = 1'b1; w_s_tdata = 32'h3FF; w_s_tlast = 1'b0;
    #1;
    checks++; if (w_s_tready !== 1'b0) begin errors++; $display("[TB] FAIL flush_tready_low: got %b expected 0", w_s_tready); end
    @(negedge aclk);
    flush = 1'b0; w_s_tvalid = 1'b0;
    #1;
    checks++; if (w_count !== 5'd0 || w_packets !== 5'd0) begin errors++; $display("[TB] FAIL flush_clear: got count=%0d packets=%0d expected 0 0", w_count, w_packets); end
    checks++; if (w_m_tvalid !== 1'b0 || w_s_tready !== 1'b1) begin errors++; $display("[TB] FAIL flush_handshake: got tvalid=%b tready=%b expected 0 1", w_m_tvalid, w_s_tready); end
  endtask

  task automatic test_async_reset();
    w_m_tready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      w_s_tvalid = 1'b1; w_s_tdata = 32'h400 + 32'(k); w_s_tlast = 1'b0;
      @(negedge aclk);
    end
    w_s_tvalid = 1'b0;
    checks++; if (w_m_tvalid !== 1'b1 || w_count !== 5'd3) begin errors++; $display("[TB] FAIL areset_pre: got v=%b count=%0d expected v=1 count=3", w_m_tvalid, w_count); end
    #2 areset = 1'b1;
    #1;
    checks++; if (w_m_tvalid !== 1'b0 || w_count !== 5'd0) begin errors++; $display("[TB] FAIL areset_async: got v=%b count=%0d expected v=0 count=0", w_m_tvalid, w_count); end
    @(negedge aclk); areset = 1'b0;
    @(negedge aclk);
    checks++; if (w_s_tready !== 1'b1 || w_m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL areset_after: got tready=%b tvalid=%b expected 1 0", w_s_tready, w_m_tvalid); end
    w_s_tvalid = 1'b1; w_s_tdata = 32'h4AA;
    @(negedge aclk);
    w_s_tvalid = 1'b0;
    @(negedge aclk);
    checks++; if (w_m_tvalid !== 1'b1 || w_m_tdata !== 32'h4AA || w_count !== 5'd1) begin errors++; $display("[TB] FAIL areset_fresh: got v=%b d=%0h count=%0d expected v=1 d=4aa count=1", w_m_tvalid, w_m_tdata, w_count); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_word_fill();
    test_stream();
    test_packet();
    test_oversize();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
